// File: rtl/kmbox_spi_master.sv
// kmbox_spi_master
// SPI mode-0 master that sends one 64-bit KMBox packet MSB-first per accepted
// word and returns the 64 bits captured on MISO during the same transaction.
//
// Handshake: a word is accepted on any clk edge where tx_valid && tx_ready.
// tx_ready is high only while idle; tx_valid/tx_data are ignored while busy.
// rx_valid is a one-cycle pulse with no back-pressure: rx_data is updated on
// that pulse and then holds until the next completed transaction.
module kmbox_spi_master #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int PH_W    = $clog2(CLK_DIV);
    localparam int CNT_MAX = (CS_SETUP > CS_HOLD)
                           ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                           : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t            state;
    logic [62:0]       tx_sh;    // bits still to send after the one on MOSI
    logic [63:0]       rx_sh;
    logic [6:0]        bit_cnt;  // falling edges seen, 0..64
    logic [PH_W-1:0]   ph_cnt;   // clk cycles into the current SCK half-period
    logic [CNT_W-1:0]  cnt;      // cycle counter for SETUP / HOLD / GAP
    logic              miso_q;

    // Single input register on MISO; the slave only changes it on falling
    // edges, so it is long stable by the time the high phase ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= spi_miso;
        end
    end

    // Transaction FSM; every SPI and handshake output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            ph_cnt   <= '0;
            cnt      <= '0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_sck  <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sh    <= tx_data[62:0];
                        spi_mosi <= tx_data[63];
                        rx_sh    <= '0;
                        spi_cs_n <= 1'b0;
                        tx_ready <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SETUP;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        ph_cnt  <= '0;
                        bit_cnt <= '0;
                        spi_sck <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (ph_cnt != PH_LAST) begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end else begin
                        ph_cnt <= '0;
                        if (spi_sck) begin
                            // End of a high phase: sample, then fall.
                            rx_sh   <= {rx_sh[62:0], miso_q};
                            spi_sck <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt != 7'd63) begin
                                spi_mosi <= tx_sh[62];
                                tx_sh    <= {tx_sh[61:0], 1'b0};
                            end
                        end else if (bit_cnt == 7'd64) begin
                            // 64th low phase finished; MOSI keeps bit 0.
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            spi_sck <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        state    <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmbox_spi_master.sv
// Bench for kmbox_spi_master: two instances (default timing and a slow-clock
// variant) driven from a vector table plus random packets, checked against a
// transaction-level model of bits and cycle offsets.
module tb_kmbox_spi_master;

    // Offsets below are counted in clk edges from the accept edge A; a value
    // registered at edge A+k is what the monitor sees in the following cycle.
    function automatic int p_div(input int d);   return (d == 0) ? 2 : 4; endfunction
    function automatic int p_setup(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int p_hold(input int d);  return (d == 0) ? 2 : 3; endfunction
    function automatic int p_gap(input int d);   return (d == 0) ? 4 : 1; endfunction
    function automatic int exp_low(input int d);
        return p_setup(d) + 128 * p_div(d) + p_hold(d);
    endfunction

    // Modes: 0 loopback, 1 MISO held high, 2 MISO held low, 3 MISO pattern.
    function automatic logic [63:0] model_rx(input int mode, input logic [63:0] data,
                                             input logic [63:0] p);
        case (mode)
            0:       return data;
            1:       return '1;
            2:       return '0;
            default: return p;
        endcase
    endfunction

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0][63:0] tx_data = '0;
    logic [1:0]       tx_valid = '0;
    logic [1:0]       loopback = '0;
    logic [1:0]       miso_drv = '0;
    wire  [1:0]       tx_ready, rx_valid, sck, cs_n, mosi, miso;
    wire  [1:0][63:0] rx_data;

    assign miso = (loopback & mosi) | (~loopback & miso_drv);

    always #5 clk = ~clk;

    kmbox_spi_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .spi_sck(sck[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

    kmbox_spi_master #(.CLK_DIV(4), .CS_SETUP(1), .CS_HOLD(3), .CS_GAP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .spi_sck(sck[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input string what,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // Monitor state (written only by the monitor process).
    logic [63:0] pat [2];
    bit          in_txn [2];
    bit          prev_sck [2], prev_rdy [2];
    int          acc_cnt [2], done_cnt [2], acc_s [2], prev_acc_s [2];
    int          miso_idx [2], hi_run [2], last_gap [2], rxv_total [2];
    int          t_rises [2], t_low [2], t_bad [2], t_rxv [2], t_rxv_s [2], t_first [2];
    logic [63:0] t_mosi [2], t_rx [2];
    int          r_rises [2], r_low [2], r_bad [2], r_rxv [2], r_rxv_off [2];
    int          r_rdy_off [2], r_first [2];
    logic [63:0] r_mosi [2], r_rx [2];

    // Sample every output on the falling clk edge and rebuild each
    // transaction: MOSI bits at SCK rises, MISO stimulus at SCK falls.
    initial begin
        for (int d = 0; d < 2; d++) begin
            in_txn[d] = 0; prev_sck[d] = 0; prev_rdy[d] = 0; acc_cnt[d] = 0;
            done_cnt[d] = 0; acc_s[d] = 0; prev_acc_s[d] = 0; hi_run[d] = 0;
            last_gap[d] = 0; rxv_total[d] = 0; miso_idx[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    in_txn[d] = 0;
                    miso_drv[d] = 1'b0;
                end
                if (cs_n[d]) hi_run[d]++;
                else begin
                    if (hi_run[d] > 0) last_gap[d] = hi_run[d];
                    hi_run[d] = 0;
                end
                if (rx_valid[d]) rxv_total[d]++;
                if (in_txn[d]) begin
                    if (!cs_n[d]) t_low[d]++;
                    if (sck[d] && cs_n[d]) t_bad[d]++;
                    if (sck[d] && !prev_sck[d]) begin
                        if (t_rises[d] == 0) t_first[d] = cyc - acc_s[d];
                        t_rises[d]++;
                        t_mosi[d] = {t_mosi[d][62:0], mosi[d]};
                    end
                    if (!sck[d] && prev_sck[d]) begin
                        miso_idx[d]++;
                        miso_drv[d] = (miso_idx[d] < 64) ? pat[d][63 - miso_idx[d]] : 1'b0;
                    end
                    if (rx_valid[d]) begin
                        t_rxv[d]++;
                        t_rxv_s[d] = cyc;
                        t_rx[d] = rx_data[d];
                    end
                    if (tx_ready[d] && !prev_rdy[d]) begin
                        r_rises[d] = t_rises[d]; r_low[d] = t_low[d]; r_bad[d] = t_bad[d];
                        r_rxv[d] = t_rxv[d]; r_rxv_off[d] = t_rxv_s[d] - acc_s[d];
                        r_rdy_off[d] = cyc - acc_s[d]; r_first[d] = t_first[d];
                        r_mosi[d] = t_mosi[d]; r_rx[d] = t_rx[d];
                        done_cnt[d]++;
                        in_txn[d] = 0;
                    end
                end
                if (rst_n && tx_valid[d] && tx_ready[d]) begin
                    prev_acc_s[d] = acc_s[d];
                    acc_s[d] = cyc + 1;
                    acc_cnt[d]++;
                    in_txn[d] = 1;
                    t_rises[d] = 0; t_low[d] = 0; t_bad[d] = 0; t_rxv[d] = 0;
                    t_rxv_s[d] = 0; t_first[d] = -1; t_mosi[d] = '0; t_rx[d] = '0;
                    miso_idx[d] = 0;
                    miso_drv[d] = pat[d][63];
                end
                prev_sck[d] = sck[d];
                prev_rdy[d] = tx_ready[d];
            end
        end
    end

    // Present a word and wait (bounded) until it has been accepted.
    task automatic start_txn(input int d, input logic [63:0] data, input int mode,
                             input logic [63:0] p, input string tag);
        int target;
        target = acc_cnt[d] + 1;
        loopback[d] = (mode == 0);
        pat[d] = model_rx(mode, data, p);
        @(posedge clk); #1;
        tx_data[d] = data;
        tx_valid[d] = 1'b1;
        for (int i = 0; i < 3000 && acc_cnt[d] < target; i++) begin
            @(posedge clk); #1;
        end
        check(tag, "accepted", 64'(acc_cnt[d] >= target), 64'd1);
    endtask

    // Wait (bounded) for completion and compare the whole transaction.
    task automatic finish_txn(input int d, input int target, input logic [63:0] exp_mosi,
                              input logic [63:0] exp_rx, input string tag);
        for (int i = 0; i < 3000 && done_cnt[d] < target; i++) begin
            @(posedge clk); #1;
        end
        check(tag, "completed", 64'(done_cnt[d] >= target), 64'd1);
        if (done_cnt[d] >= target) begin
            check(tag, "mosi bits", r_mosi[d], exp_mosi);
            check(tag, "rx at pulse", r_rx[d], exp_rx);
            check(tag, "rx_data held", rx_data[d], exp_rx);
            check(tag, "sck rises", 64'(r_rises[d]), 64'd64);
            check(tag, "first rise", 64'(r_first[d]), 64'(p_setup(d)));
            check(tag, "cs low cycles", 64'(r_low[d]), 64'(exp_low(d)));
            check(tag, "rx_valid pulses", 64'(r_rxv[d]), 64'd1);
            check(tag, "rx_valid time", 64'(r_rxv_off[d]), 64'(exp_low(d)));
            check(tag, "tx_ready time", 64'(r_rdy_off[d]), 64'(exp_low(d) + p_gap(d)));
            check(tag, "sck with cs high", 64'(r_bad[d]), 64'd0);
        end
    endtask

    typedef struct {
        int          dut;
        int          mode;
        logic [63:0] data;
        logic [63:0] p;
        logic [63:0] exp_rx;
    } vec_t;

    vec_t vecs [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tgt, n_acc, rv;
        logic [63:0] d1, d2;
        vec_t        v;

        vecs.push_back('{0, 0, 64'hA55A_0102_0304_0506, '0, 64'hA55A_0102_0304_0506});
        vecs.push_back('{0, 1, 64'h0123_4567_89AB_CDEF, '0, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{0, 2, 64'hFEDC_BA98_7654_3210, '0, 64'h0000_0000_0000_0000});
        vecs.push_back('{0, 3, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001,
                         64'h8000_0000_0000_0001});
        vecs.push_back('{1, 0, 64'hA55A_0102_0304_0506, '0, 64'hA55A_0102_0304_0506});
        vecs.push_back('{1, 3, 64'h1111_2222_3333_4444, 64'hC3C3_0F0F_5A5A_9696,
                         64'hC3C3_0F0F_5A5A_9696});
        for (int i = 0; i < 8; i++) begin
            v.dut  = (i < 6) ? 0 : 1;
            v.mode = int'($urandom_range(0, 3));
            v.data = {$urandom, $urandom};
            v.p    = {$urandom, $urandom};
            v.exp_rx = model_rx(v.mode, v.data, v.p);
            vecs.push_back(v);
        end

        // Reset values while rst_n is held low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset", "tx_ready", 64'(tx_ready[d]), 64'd0);
            check("reset", "rx_valid", 64'(rx_valid[d]), 64'd0);
            check("reset", "rx_data", rx_data[d], 64'd0);
            check("reset", "spi_sck", 64'(sck[d]), 64'd0);
            check("reset", "spi_cs_n", 64'(cs_n[d]), 64'd1);
            check("reset", "spi_mosi", 64'(mosi[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++)
            check("reset", "tx_ready after release", 64'(tx_ready[d]), 64'd1);

        // Vector table; tx_data is scrambled right after each accept.
        foreach (vecs[i]) begin
            v = vecs[i];
            repeat ($urandom_range(0, 5)) @(posedge clk);
            tgt = done_cnt[v.dut] + 1;
            start_txn(v.dut, v.data, v.mode, v.p, $sformatf("vec%0d", i));
            tx_valid[v.dut] = 1'b0;
            tx_data[v.dut] = {$urandom, $urandom};
            finish_txn(v.dut, tgt, v.data, v.exp_rx, $sformatf("vec%0d", i));
        end

        // Back-to-back: tx_valid stays high and the source queues a second word.
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        n_acc = acc_cnt[0];
        tgt = done_cnt[0] + 1;
        start_txn(0, d1, 0, '0, "b2b first");
        tx_data[0] = d2;
        finish_txn(0, tgt, d1, d1, "b2b first");
        for (int i = 0; i < 50 && acc_cnt[0] < n_acc + 2; i++) begin
            @(posedge clk); #1;
        end
        tx_valid[0] = 1'b0;
        check("b2b", "second accepted", 64'(acc_cnt[0] >= n_acc + 2), 64'd1);
        @(negedge clk); #1;
        check("b2b", "accept spacing", 64'(acc_s[0] - prev_acc_s[0]),
              64'(exp_low(0) + p_gap(0) + 1));
        check("b2b", "cs high cycles", 64'(last_gap[0]), 64'(p_gap(0) + 1));
        finish_txn(0, tgt + 1, d2, d2, "b2b second");

        // Asynchronous reset in the middle of a transfer.
        d1 = {$urandom, $urandom};
        tgt = done_cnt[0];
        rv = rxv_total[0];
        start_txn(0, d1, 0, '0, "abort");
        tx_valid[0] = 1'b0;
        repeat (99) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort", "spi_cs_n", 64'(cs_n[0]), 64'd1);
        check("abort", "spi_sck", 64'(sck[0]), 64'd0);
        check("abort", "tx_ready", 64'(tx_ready[0]), 64'd0);
        check("abort", "spi_mosi", 64'(mosi[0]), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort", "tx_ready after release", 64'(tx_ready[0]), 64'd1);
        check("abort", "rx_data cleared", rx_data[0], 64'd0);
        repeat (20) @(posedge clk);
        check("abort", "no rx_valid", 64'(rxv_total[0] - rv), 64'd0);
        check("abort", "no completion", 64'(done_cnt[0] - tgt), 64'd0);
        d2 = {$urandom, $urandom};
        start_txn(0, d2, 0, '0, "after abort");
        tx_valid[0] = 1'b0;
        finish_txn(0, tgt + 1, d2, d2, "after abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
